grid_io_cfg_bank: RTL and testbench

Parametrised IO grid tile with on-tile configuration storage. Replaces per-pad raw `bl`/`wl` wiring with a handshaked memory-bank style write/read port. Writes land in shadow words and move atomically to active words on a commit, so pad directions change glitch-free. Sits at the fabric edge between the routing-side `io_top_*` nets and external pad cells; pad input is synchronised before entering the fabric.

---
 rtl/grid_io_cfg_bank.sv | 142 ++++++++++++++
 tb/tb_grid_io_cfg_bank.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/grid_io_cfg_bank.sv
// Purpose: IO grid tile with handshaked shadow/active config words driving pad oe and input gating.
// Latency: write holds the port WL_PULSE cycles, read data one cycle after accept, commit visible next cycle, pad-in SYNC_STAGES cycles.
// Backpressure: cfg_ready drops while a write pulse or read is in flight; a request not accepted is ignored and must be held.
//
// Ports:
//   prog_clk, pReset              - clock, synchronous active-high reset
//   cfg_valid/cfg_ready/cfg_we    - request handshake, 1 = write, 0 = read
//   cfg_addr                      - 0 shadow OE, 1 shadow IE, 2 active OE (ro), 3 active IE (ro)
//   cfg_data/cfg_rdata/cfg_rvalid - write word, read word, one-cycle read strobe
//   cfg_commit                    - level-sampled copy of shadow words into active words
//   gfpga_pad_GPIO_PAD_*          - pad cell in/out/oe
//   io_top_out/io_top_in          - fabric-side pad data
module grid_io_cfg_bank #(
  parameter int NUM_IO      = 8,
  parameter int WL_PULSE    = 2,
  parameter int SYNC_STAGES = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic              cfg_we,
  input  logic [1:0]        cfg_addr,
  input  logic [NUM_IO-1:0] cfg_data,
  output logic [NUM_IO-1:0] cfg_rdata,
  output logic              cfg_rvalid,
  input  logic              cfg_commit,
  input  logic [NUM_IO-1:0] gfpga_pad_GPIO_PAD_in,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_PAD_out,
  output logic [NUM_IO-1:0] gfpga_pad_GPIO_PAD_oe,
  input  logic [NUM_IO-1:0] io_top_out,
  output logic [NUM_IO-1:0] io_top_in
);

  localparam int CNT_W = (WL_PULSE > 1) ? $clog2(WL_PULSE) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    READ  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_IO-1:0] sh_oe, sh_ie, act_oe, act_ie;
  logic [NUM_IO-1:0] sh_oe_next, sh_ie_next;
  logic [NUM_IO-1:0] rd_sel;
  logic [NUM_IO-1:0] rdata_q;
  logic              wr_accept, rd_accept;
  logic [NUM_IO-1:0] sync_q [SYNC_STAGES];

  // Ready is masked by reset so nothing can be accepted on a reset edge.
  assign cfg_ready = (state_q == IDLE) && !pReset;
  assign wr_accept = cfg_valid && cfg_ready && cfg_we;
  assign rd_accept = cfg_valid && cfg_ready && !cfg_we;

  // Shadow values including a write accepted this cycle, so a coincident
  // commit picks the new word up.
  assign sh_oe_next = (wr_accept && cfg_addr == 2'd0) ? cfg_data : sh_oe;
  assign sh_ie_next = (wr_accept && cfg_addr == 2'd1) ? cfg_data : sh_ie;

  always_comb begin
    rd_sel = '0;
    case (cfg_addr)
      2'd0:    rd_sel = sh_oe;
      2'd1:    rd_sel = sh_ie;
      2'd2:    rd_sel = act_oe;
      default: rd_sel = act_ie;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (wr_accept) begin
          state_d = PULSE;
          cnt_d   = '0;
        end else if (rd_accept) begin
          state_d = READ;
        end
      end
      PULSE: begin
        if (cnt_q == CNT_W'(WL_PULSE - 1)) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      READ:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sh_oe   <= '0;
      sh_ie   <= '0;
      act_oe  <= '0;
      act_ie  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_oe   <= sh_oe_next;
      sh_ie   <= sh_ie_next;
      if (cfg_commit) begin
        act_oe <= sh_oe_next;
        act_ie <= sh_ie_next;
      end
      if (rd_accept) begin
        rdata_q <= rd_sel;
      end
    end
  end

  // Pad-input synchroniser; the act_ie gate sits after the chain so a
  // direction change never opens a path around the flops.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= gfpga_pad_GPIO_PAD_in;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Strobe is masked by reset so an aborted read never reports data.
  assign cfg_rvalid             = (state_q == READ) && !pReset;
  assign cfg_rdata              = rdata_q;
  assign gfpga_pad_GPIO_PAD_oe  = act_oe;
  assign gfpga_pad_GPIO_PAD_out = io_top_out & act_oe;
  assign io_top_in              = sync_q[SYNC_STAGES-1] & act_ie;

endmodule

// File: tb/tb_grid_io_cfg_bank.sv
module tb_grid_io_cfg_bank;
  localparam int NUM_IO      = 8;
  localparam int WL_PULSE    = 2;
  localparam int SYNC_STAGES = 2;

  logic              prog_clk = 1'b0;
  logic              pReset;
  logic              cfg_valid, cfg_we, cfg_commit;
  logic [1:0]        cfg_addr;
  logic [NUM_IO-1:0] cfg_data, pad_in, io_top_out;
  logic              cfg_ready, cfg_rvalid;
  logic [NUM_IO-1:0] cfg_rdata, pad_out, pad_oe, io_top_in;

  always #5 prog_clk = ~prog_clk;

  grid_io_cfg_bank #(
    .NUM_IO(NUM_IO), .WL_PULSE(WL_PULSE), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .prog_clk(prog_clk),
    .pReset(pReset),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_we(cfg_we),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .cfg_rdata(cfg_rdata),
    .cfg_rvalid(cfg_rvalid),
    .cfg_commit(cfg_commit),
    .gfpga_pad_GPIO_PAD_in(pad_in),
    .gfpga_pad_GPIO_PAD_out(pad_out),
    .gfpga_pad_GPIO_PAD_oe(pad_oe),
    .io_top_out(io_top_out),
    .io_top_in(io_top_in)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: register file indexed by address, busy countdown,
  // and a history of pad-input samples (newest first).
  logic [NUM_IO-1:0] m_reg [4] = '{default: '0};
  int                m_busy = 0;
  bit                m_rv = 1'b0;
  logic [NUM_IO-1:0] m_rdata = '0;
  logic [NUM_IO-1:0] m_hist [$];

  int dut_acc = 0;
  int dut_rv  = 0;
  bit last_acc = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_ready"},  cfg_ready,  (m_busy == 0) && !pReset);
    check({tag, "_rvalid"}, cfg_rvalid, m_rv && !pReset);
    check({tag, "_rdata"},  cfg_rdata,  m_rdata);
    check({tag, "_oe"},     pad_oe,     m_reg[2]);
    check({tag, "_padout"}, pad_out,    io_top_out & m_reg[2]);
    check({tag, "_topin"},  io_top_in,  m_hist[SYNC_STAGES-1] & m_reg[3]);
  endtask

  task automatic model_edge();
    bit                acc;
    logic [NUM_IO-1:0] n_oe, n_ie;
    if (pReset) begin
      for (int i = 0; i < 4; i++) m_reg[i] = '0;
      m_busy  = 0;
      m_rv    = 1'b0;
      m_rdata = '0;
      for (int i = 0; i < SYNC_STAGES; i++) m_hist[i] = '0;
    end else begin
      acc  = cfg_valid && (m_busy == 0);
      n_oe = m_reg[0];
      n_ie = m_reg[1];
      if (m_busy > 0) m_busy--;
      m_rv = 1'b0;
      if (acc && cfg_we) begin
        if (cfg_addr == 2'd0) n_oe = cfg_data;
        if (cfg_addr == 2'd1) n_ie = cfg_data;
        m_busy = WL_PULSE;
      end
      if (acc && !cfg_we) begin
        m_rdata = m_reg[cfg_addr];
        m_rv    = 1'b1;
        m_busy  = 1;
      end
      m_reg[0] = n_oe;
      m_reg[1] = n_ie;
      if (cfg_commit) begin
        m_reg[2] = n_oe;
        m_reg[3] = n_ie;
      end
      m_hist.push_front(pad_in);
      void'(m_hist.pop_back());
    end
  endtask

  // One clock: settle, check against model, advance model, take the edge.
  task automatic step(input string tag, input bit do_chk);
    #1;
    if (do_chk) check_all(tag);
    last_acc = cfg_valid && cfg_ready;
    if (last_acc) dut_acc++;
    if (cfg_rvalid) dut_rv++;
    model_edge();
    @(posedge prog_clk);
    #1;
  endtask

  task automatic req(input bit we, input logic [1:0] addr, input logic [NUM_IO-1:0] data);
    cfg_valid = 1'b1;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_data  = data;
  endtask

  initial begin
    int exp_acc, exp_rv, t;
    bit rd;

    pReset = 1'b1; cfg_valid = 1'b0; cfg_we = 1'b0; cfg_addr = '0;
    cfg_data = '0; cfg_commit = 1'b0; pad_in = '0; io_top_out = '0;
    for (int i = 0; i < SYNC_STAGES; i++) m_hist.push_back('0);
    @(posedge prog_clk);
    #1;
    step("rst", 1'b0);
    step("rst_hold", 1'b1);
    pReset = 1'b0;
    for (int i = 0; i < 3; i++) step("idle", 1'b1);
    check("idle_ready", cfg_ready, 1'b1);
    check("idle_oe", pad_oe, 8'h00);
    check("idle_topin", io_top_in, 8'h00);

    // Shadow write, pulse stall.
    req(1'b1, 2'd0, 8'hA5);
    step("wr_a5", 1'b1);
    cfg_valid = 1'b0;
    check("pulse1_ready", cfg_ready, 1'b0);
    step("pulse1", 1'b1);
    check("pulse2_ready", cfg_ready, 1'b0);
    step("pulse2", 1'b1);
    check("after_pulse_ready", cfg_ready, 1'b1);

    req(1'b0, 2'd2, 8'h00);
    step("rd_act_oe", 1'b1);
    cfg_valid = 1'b0;
    check("rd2_rvalid", cfg_rvalid, 1'b1);
    check("rd2_rdata", cfg_rdata, 8'h00);
    check("rd2_ready", cfg_ready, 1'b0);
    step("rd2_cyc", 1'b1);

    req(1'b0, 2'd0, 8'h00);
    step("rd_sh_oe", 1'b1);
    cfg_valid = 1'b0;
    check("rd0_rvalid", cfg_rvalid, 1'b1);
    check("rd0_rdata", cfg_rdata, 8'hA5);
    step("rd0_cyc", 1'b1);
    check("rd0_hold", cfg_rdata, 8'hA5);

    // Write with coincident commit.
    req(1'b1, 2'd1, 8'hFF);
    cfg_commit = 1'b1;
    step("wr_ie_commit", 1'b1);
    cfg_valid = 1'b0; cfg_commit = 1'b0;
    check("commit_oe", pad_oe, 8'hA5);
    check("commit_topin0", io_top_in, 8'h00);
    pad_in = 8'h3C;
    step("sync1", 1'b1);
    check("sync_lat1", io_top_in, 8'h00);
    step("sync2", 1'b1);
    check("sync_lat2", io_top_in, 8'h3C);
    io_top_out = 8'hFF;
    #1;
    check("comb_padout", pad_out, 8'hA5);
    check("comb_oe", pad_oe, 8'hA5);
    step("settle", 1'b1);

    // Write to a read-only address is discarded but still stalls.
    req(1'b1, 2'd2, 8'h55);
    step("wr_ro", 1'b1);
    cfg_valid = 1'b0;
    check("ro_pulse1", cfg_ready, 1'b0);
    step("ro_p1", 1'b1);
    check("ro_pulse2", cfg_ready, 1'b0);
    step("ro_p2", 1'b1);
    check("ro_idle", cfg_ready, 1'b1);
    cfg_commit = 1'b1;
    step("ro_commit", 1'b1);
    cfg_commit = 1'b0;
    check("ro_commit_oe", pad_oe, 8'hA5);

    // Reset in the first pulse cycle.
    req(1'b1, 2'd0, 8'h0F);
    step("wr_pre_rst", 1'b1);
    cfg_valid = 1'b0;
    pReset = 1'b1;
    #1;
    check("rst_mid_ready", cfg_ready, 1'b0);
    step("rst_mid", 1'b1);
    check("rst_oe", pad_oe, 8'h00);
    check("rst_topin", io_top_in, 8'h00);
    check("rst_rdata", cfg_rdata, 8'h00);
    step("rst_mid2", 1'b1);
    pReset = 1'b0;
    #1;
    check("rst_release_ready", cfg_ready, 1'b1);
    step("rst_rel", 1'b1);

    // Read immediately followed by reset: no strobe.
    req(1'b0, 2'd1, 8'h00);
    step("rd_pre_rst", 1'b1);
    cfg_valid = 1'b0;
    pReset = 1'b1;
    #1;
    check("rd_rst_rvalid", cfg_rvalid, 1'b0);
    step("rd_rst", 1'b1);
    pReset = 1'b0;
    step("rd_rst_rel", 1'b1);

    // Held valid, alternating read/write over 20 cycles.
    exp_acc = 0; exp_rv = 0; t = 0; rd = 1'b1;
    while (t < 20) begin
      exp_acc++;
      if (rd) begin
        if (t + 1 < 20) exp_rv++;
        t += 2;
      end else begin
        t += WL_PULSE + 1;
      end
      rd = !rd;
    end
    dut_acc = 0; dut_rv = 0;
    rd = 1'b1;
    req(1'b0, 2'd1, 8'h00);
    for (int i = 0; i < 20; i++) begin
      step("alt", 1'b1);
      if (last_acc) begin
        rd = !rd;
        req(!rd, rd ? 2'd1 : 2'd0, 8'($urandom));
      end
    end
    cfg_valid = 1'b0;
    check("alt_acc_count", dut_acc, exp_acc);
    check("alt_rv_count", dut_rv, exp_rv);
    step("alt_end", 1'b1);
    step("alt_end2", 1'b1);
    step("alt_end3", 1'b1);

    // Randomised traffic against the model.
    for (int i = 0; i < 400; i++) begin
      pReset     = ($urandom_range(0, 39) == 0);
      cfg_valid  = ($urandom_range(0, 2) != 0);
      cfg_we     = $urandom_range(0, 1) == 1;
      cfg_addr   = 2'($urandom_range(0, 3));
      cfg_data   = 8'($urandom);
      cfg_commit = ($urandom_range(0, 3) == 0);
      pad_in     = 8'($urandom);
      io_top_out = 8'($urandom);
      step("rnd", 1'b1);
    end
    pReset = 1'b0; cfg_valid = 1'b0; cfg_commit = 1'b0;
    step("final", 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
